// File: rtl/sb_spram256ka_pkg.sv
// Shared constants and access-mode decode for the 256 Kbit single-port frame buffer RAM.
package spram_pkg;

  localparam int SPRAM_ADDR_WIDTH = 14;
  localparam int SPRAM_DATA_WIDTH = 16;
  localparam int SPRAM_NIBBLES    = 4;
  localparam int SPRAM_DEPTH      = 16384;

  // What the RAM does at the next rising edge, after applying the power-control priority.
  typedef enum logic [2:0] {
    MODE_OFF   = 3'd0,  // powered off: contents lost, output cleared
    MODE_SLEEP = 3'd1,  // sleeping: contents kept, output cleared
    MODE_HOLD  = 3'd2,  // deselected or standby: nothing changes
    MODE_READ  = 3'd3,
    MODE_WRITE = 3'd4
  } spram_mode_e;

  // POWEROFF (active-low) beats SLEEP, which beats STANDBY/CHIPSELECT.
  function automatic spram_mode_e spram_decode(input logic chipselect,
                                               input logic standby,
                                               input logic sleep,
                                               input logic poweroff,
                                               input logic wren);
    spram_mode_e m;
    if (!poweroff) begin
      m = MODE_OFF;
    end else if (sleep) begin
      m = MODE_SLEEP;
    end else if (standby || !chipselect) begin
      m = MODE_HOLD;
    end else if (wren) begin
      m = MODE_WRITE;
    end else begin
      m = MODE_READ;
    end
    return m;
  endfunction

endpackage

// File: rtl/sb_spram256ka_if.sv
// Bus bundle between a frame-buffer user (master) and the single-port RAM (slave).
interface sb_spram256ka_if;
  import spram_pkg::*;

  logic [SPRAM_ADDR_WIDTH-1:0] ADDRESS;
  logic [SPRAM_DATA_WIDTH-1:0] DATAIN;
  logic [SPRAM_NIBBLES-1:0]    MASKWREN;
  logic                        WREN;
  logic                        CHIPSELECT;
  logic                        STANDBY;
  logic                        SLEEP;
  logic                        POWEROFF;
  logic [SPRAM_DATA_WIDTH-1:0] DATAOUT;

  modport master (
    output ADDRESS, DATAIN, MASKWREN, WREN, CHIPSELECT, STANDBY, SLEEP, POWEROFF,
    input  DATAOUT
  );

  modport slave (
    input  ADDRESS, DATAIN, MASKWREN, WREN, CHIPSELECT, STANDBY, SLEEP, POWEROFF,
    output DATAOUT
  );

endinterface

// File: rtl/sb_spram256ka.sv
// 16K x 16 single-port RAM with nibble write masks, registered read and power-down modes.
module sb_spram256ka
  import spram_pkg::*;
#(
  parameter int ADDR_WIDTH = SPRAM_ADDR_WIDTH,
  parameter int DATA_WIDTH = SPRAM_DATA_WIDTH
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  sb_spram256ka_if.slave  bus
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] dataout_reg;
  logic [DATA_WIDTH-1:0] bit_en;
  logic [DATA_WIDTH-1:0] merged_word;
  spram_mode_e           mode;

  // Expand one enable bit per nibble into a per-bit write enable.
  function automatic logic [DATA_WIDTH-1:0] nibble_bits(input logic [SPRAM_NIBBLES-1:0] m);
    logic [DATA_WIDTH-1:0] b;
    b = '0;
    for (int n = 0; n < SPRAM_NIBBLES; n++) begin
      b[4*n +: 4] = {4{m[n]}};
    end
    return b;
  endfunction

  // Decode the access mode and build the masked write word.
  always_comb begin
    mode        = spram_decode(bus.CHIPSELECT, bus.STANDBY, bus.SLEEP, bus.POWEROFF, bus.WREN);
    bit_en      = nibble_bits(bus.MASKWREN);
    merged_word = (mem[bus.ADDRESS] & ~bit_en) | (bus.DATAIN & bit_en);
  end

  // Array update: masked write, or wipe of every word while powered off.
  // Contents survive reset, but no edge during reset may modify them.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      // array intentionally left untouched
    end else if (mode == MODE_OFF) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (mode == MODE_WRITE) begin
      mem[bus.ADDRESS] <= merged_word;
    end
  end

  // Output register: loads on reads, clears in sleep/power-off, holds otherwise.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      dataout_reg <= '0;
    end else begin
      case (mode)
        MODE_OFF, MODE_SLEEP: dataout_reg <= '0;
        MODE_READ:            dataout_reg <= mem[bus.ADDRESS];
        default:              dataout_reg <= dataout_reg;
      endcase
    end
  end

  // Drive the registered read data onto the bus.
  always_comb begin
    bus.DATAOUT = dataout_reg;
  end

endmodule

// File: tb/tb_sb_spram256ka.sv
// Randomised and directed checks of the frame-buffer RAM against a behavioural model.
module tb_sb_spram256ka;
  import spram_pkg::*;

  logic clk_i;
  logic rst_ni;
  sb_spram256ka_if bus();

  sb_spram256ka dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;
  int txn   = 0;

  logic [15:0] model_mem [SPRAM_DEPTH];
  logic [15:0] model_dout;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference behaviour of one rising edge, from the current bus inputs.
  task automatic model_edge();
    if (!rst_ni) begin
      model_dout = 16'h0000;
    end else if (!bus.POWEROFF) begin
      model_dout = 16'h0000;
      for (int i = 0; i < SPRAM_DEPTH; i++) model_mem[i] = 16'h0000;
    end else if (bus.SLEEP) begin
      model_dout = 16'h0000;
    end else if (bus.STANDBY || !bus.CHIPSELECT) begin
      model_dout = model_dout;
    end else if (bus.WREN) begin
      for (int n = 0; n < 4; n++)
        if (bus.MASKWREN[n]) model_mem[bus.ADDRESS][4*n +: 4] = bus.DATAIN[4*n +: 4];
    end else begin
      model_dout = model_mem[bus.ADDRESS];
    end
  endtask

  task automatic step(input string tag, input logic [13:0] a, input logic [15:0] d,
                      input logic [3:0] m, input logic we, input logic cs,
                      input logic sb, input logic sl, input logic po);
    bus.ADDRESS = a; bus.DATAIN = d; bus.MASKWREN = m; bus.WREN = we;
    bus.CHIPSELECT = cs; bus.STANDBY = sb; bus.SLEEP = sl; bus.POWEROFF = po;
    @(posedge clk_i);
    model_edge();
    #1;
    txn++;
    $display("txn %0d %s a=%h d=%h m=%b we=%b cs=%b sb=%b sl=%b po=%b dout=%h exp=%h",
             txn, tag, a, d, m, we, cs, sb, sl, po, bus.DATAOUT, model_dout);
    check(tag, bus.DATAOUT, model_dout);
  endtask

  task automatic wr(input string tag, input logic [13:0] a, input logic [15:0] d, input logic [3:0] m);
    step(tag, a, d, m, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic rd(input string tag, input logic [13:0] a);
    step(tag, a, 16'h0000, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    rst_ni = 1'b0;
    bus.ADDRESS = '0; bus.DATAIN = '0; bus.MASKWREN = '0; bus.WREN = 1'b0;
    bus.CHIPSELECT = 1'b0; bus.STANDBY = 1'b0; bus.SLEEP = 1'b0; bus.POWEROFF = 1'b1;
    model_dout = 16'h0000;
    repeat (2) @(posedge clk_i);
    #1;
    check("reset_dout", bus.DATAOUT, 16'h0000);
    rst_ni = 1'b1;

    // 1: full-word writes at both ends of the address range
    wr("t1_wr0", 14'h0000, 16'hBEEF, 4'b1111);
    wr("t1_wr3fff", 14'h3FFF, 16'h1234, 4'b1111);
    rd("t1_rd0", 14'h0000);
    check("t1_rd0_const", bus.DATAOUT, 16'hBEEF);
    rd("t1_rd3fff", 14'h3FFF);
    check("t1_rd3fff_const", bus.DATAOUT, 16'h1234);

    // 2: nibble masking
    wr("t2_wr_ffff", 14'd5, 16'hFFFF, 4'b1111);
    wr("t2_wr_mask0101", 14'd5, 16'h0000, 4'b0101);
    rd("t2_rd", 14'd5);
    check("t2_rd_const", bus.DATAOUT, 16'hF0F0);
    wr("t2_wr_mask0000", 14'd5, 16'h1111, 4'b0000);
    rd("t2_rd2", 14'd5);
    check("t2_rd2_const", bus.DATAOUT, 16'hF0F0);

    // 3: output holds during writes, deselect and standby
    rd("t3_rd5", 14'd5);
    wr("t3_wr6", 14'd6, 16'hAAAA, 4'b1111);
    check("t3_hold_wr", bus.DATAOUT, 16'hF0F0);
    step("t3_cs0", 14'd7, 16'h0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("t3_hold_cs0", bus.DATAOUT, 16'hF0F0);
    step("t3_stby", 14'd6, 16'h5555, 4'b1111, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    check("t3_hold_stby", bus.DATAOUT, 16'hF0F0);
    rd("t3_rd6", 14'd6);
    check("t3_rd6_const", bus.DATAOUT, 16'hAAAA);

    // 4: sleep clears the output and blocks writes
    for (int i = 0; i < 3; i++) begin
      step("t4_sleep", 14'd5, 16'h0000, 4'b1111, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
      check("t4_sleep_const", bus.DATAOUT, 16'h0000);
    end
    step("t4_exit_idle", 14'd5, 16'h0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("t4_exit_const", bus.DATAOUT, 16'h0000);
    rd("t4_rd5", 14'd5);
    check("t4_rd5_const", bus.DATAOUT, 16'hF0F0);

    // 5: power-off loses contents
    for (int i = 0; i < 2; i++) begin
      step("t5_off", 14'd5, 16'h0000, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      check("t5_off_const", bus.DATAOUT, 16'h0000);
    end
    rd("t5_rd5", 14'd5);
    check("t5_rd5_const", bus.DATAOUT, 16'h0000);
    rd("t5_rd0", 14'd0);
    check("t5_rd0_const", bus.DATAOUT, 16'h0000);

    // 6: asynchronous reset clears output, blocks writes, keeps contents
    wr("t6_wr0", 14'd0, 16'hBEEF, 4'b1111);
    rd("t6_rd0", 14'd0);
    check("t6_rd0_const", bus.DATAOUT, 16'hBEEF);
    #2;
    rst_ni = 1'b0;
    #1;
    check("t6_async_clear", bus.DATAOUT, 16'h0000);
    bus.ADDRESS = 14'd0; bus.DATAIN = 16'h5555; bus.MASKWREN = 4'b1111; bus.WREN = 1'b1;
    bus.CHIPSELECT = 1'b1; bus.STANDBY = 1'b0; bus.SLEEP = 1'b0; bus.POWEROFF = 1'b1;
    @(posedge clk_i);
    model_edge();
    #1;
    check("t6_in_reset", bus.DATAOUT, 16'h0000);
    rst_ni = 1'b1;
    rd("t6_rd_after", 14'd0);
    check("t6_rd_after_const", bus.DATAOUT, 16'hBEEF);

    // Random traffic over a few addresses including the top word
    for (int i = 0; i < 400; i++) begin
      logic [13:0] a;
      int sel;
      sel = int'($urandom_range(0, 8));
      a = (sel == 8) ? 14'h3FFF : 14'(sel);
      step("rand", a, 16'($urandom), 4'($urandom),
           1'($urandom_range(0, 1)),
           ($urandom_range(0, 9) != 0),
           ($urandom_range(0, 14) == 0),
           ($urandom_range(0, 19) == 0),
           ($urandom_range(0, 59) != 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
